// File: rtl/pdp8_mem_unit.sv
// PDP-8 main memory: 4K x 12 words, loader port, registered instruction and operand
// read ports, one operand write port with write-first forwarding to both readers.
module pdp8_mem_unit #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 4096
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_valid,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_done,
    output logic                  mem_ready,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    input  logic                  exec_rd_req,
    input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
    output logic [DATA_WIDTH-1:0] exec_rd_data,
    input  logic                  exec_wr_req,
    input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
    input  logic [DATA_WIDTH-1:0] exec_wr_data,
    output logic [ADDR_WIDTH:0]   load_count
);

    // Handshake: no valid/ready pairing on these ports; every request sampled while
    // mem_ready=1 is accepted that edge, and nothing is ever back-pressured.

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH:0] COUNT_MAX = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state_q;
    state_t                state_d;
    logic                  mem_ready_d;
    logic                  load_we;
    logic                  exec_we;
    logic                  ifu_re;
    logic                  exec_re;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_LOAD && load_done) begin
            state_d = ST_RUN;
        end
    end

    // Client ports are enabled by the registered mem_ready, so the edge that enters
    // RUN and the edge that raises mem_ready both ignore requests.
    always_comb begin
        mem_ready_d = (state_q == ST_RUN);
        load_we     = (state_q == ST_LOAD) && load_valid;
        exec_we     = mem_ready && exec_wr_req;
        ifu_re      = mem_ready && ifu_rd_req;
        exec_re     = mem_ready && exec_rd_req;
        mem_we      = load_we || exec_we;
        mem_waddr   = load_we ? load_addr : exec_wr_addr;
        mem_wdata   = load_we ? load_data : exec_wr_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_ready <= 1'b0;
        end else begin
            mem_ready <= mem_ready_d;
        end
    end

    // The array has no reset so loaded contents survive a reset.
    always_ff @(posedge clk) begin
        if (reset_n && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ifu_rd_data <= '0;
        end else if (ifu_re) begin
            if (exec_we && exec_wr_addr == ifu_rd_addr) begin
                ifu_rd_data <= exec_wr_data;
            end else begin
                ifu_rd_data <= mem[ifu_rd_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            exec_rd_data <= '0;
        end else if (exec_re) begin
            if (exec_we && exec_wr_addr == exec_rd_addr) begin
                exec_rd_data <= exec_wr_data;
            end else begin
                exec_rd_data <= mem[exec_rd_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            load_count <= '0;
        end else if (load_we && load_count != COUNT_MAX) begin
            load_count <= load_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pdp8_mem_unit.sv
// Bench for pdp8_mem_unit: directed vector table, randomized traffic against a
// word-array reference model, and a loader counter saturation run.
module tb_pdp8_mem_unit;

    localparam int AW    = 12;
    localparam int DW    = 12;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          load_valid;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          load_done;
    logic          mem_ready;
    logic          ifu_rd_req;
    logic [AW-1:0] ifu_rd_addr;
    logic [DW-1:0] ifu_rd_data;
    logic          exec_rd_req;
    logic [AW-1:0] exec_rd_addr;
    logic [DW-1:0] exec_rd_data;
    logic          exec_wr_req;
    logic [AW-1:0] exec_wr_addr;
    logic [DW-1:0] exec_wr_data;
    logic [AW:0]   load_count;

    always #5 clk = ~clk;

    pdp8_mem_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_valid   (load_valid),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .load_done    (load_done),
        .mem_ready    (mem_ready),
        .ifu_rd_req   (ifu_rd_req),
        .ifu_rd_addr  (ifu_rd_addr),
        .ifu_rd_data  (ifu_rd_data),
        .exec_rd_req  (exec_rd_req),
        .exec_rd_addr (exec_rd_addr),
        .exec_rd_data (exec_rd_data),
        .exec_wr_req  (exec_wr_req),
        .exec_wr_addr (exec_wr_addr),
        .exec_wr_data (exec_wr_data),
        .load_count   (load_count)
    );

    typedef struct {
        logic          rst_n;
        logic          lv;
        logic [AW-1:0] la;
        logic [DW-1:0] ld;
        logic          dn;
        logic          ir;
        logic [AW-1:0] ia;
        logic          er;
        logic [AW-1:0] ea;
        logic          ew;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          exp_ready;
        logic [DW-1:0] exp_ifu;
        logic [DW-1:0] exp_exec;
        logic [AW:0]   exp_cnt;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain word array plus the observable output values.
    logic [DW-1:0] ref_mem [DEPTH];
    bit            m_run;
    bit            m_ready;
    logic [DW-1:0] m_ifu;
    logic [DW-1:0] m_exec;
    int            m_cnt;

    task automatic check(input string name, input logic [AW:0] act, input logic [AW:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o, expected %0o", name, act, exp);
        end
    endtask

    task automatic model_edge();
        if (!reset_n) begin
            m_run   = 1'b0;
            m_ready = 1'b0;
            m_ifu   = '0;
            m_exec  = '0;
            m_cnt   = 0;
        end else if (!m_run) begin
            if (load_valid) begin
                ref_mem[load_addr] = load_data;
                if (m_cnt < DEPTH) m_cnt++;
            end
            if (load_done) m_run = 1'b1;
        end else begin
            if (m_ready) begin
                // Write applied first so same-address reads observe the new word.
                if (exec_wr_req) ref_mem[exec_wr_addr] = exec_wr_data;
                if (ifu_rd_req) m_ifu = ref_mem[ifu_rd_addr];
                if (exec_rd_req) m_exec = ref_mem[exec_rd_addr];
            end
            m_ready = 1'b1;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " ready"}, {12'd0, mem_ready}, {12'd0, m_ready});
        check({tag, " ifu"}, {1'b0, ifu_rd_data}, {1'b0, m_ifu});
        check({tag, " exec"}, {1'b0, exec_rd_data}, {1'b0, m_exec});
        check({tag, " count"}, load_count, (AW + 1)'(m_cnt));
    endtask

    task automatic idle_inputs();
        load_valid   = 1'b0;
        load_addr    = '0;
        load_data    = '0;
        load_done    = 1'b0;
        ifu_rd_req   = 1'b0;
        ifu_rd_addr  = '0;
        exec_rd_req  = 1'b0;
        exec_rd_addr = '0;
        exec_wr_req  = 1'b0;
        exec_wr_addr = '0;
        exec_wr_data = '0;
    endtask

    function automatic vec_t v(input logic rst, input logic lv, input logic [AW-1:0] la,
                               input logic [DW-1:0] ld, input logic dn, input logic ir,
                               input logic [AW-1:0] ia, input logic er, input logic [AW-1:0] ea,
                               input logic ew, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic rdy, input logic [DW-1:0] ei, input logic [DW-1:0] ee,
                               input logic [AW:0] ec);
        vec_t r;
        r.rst_n = rst; r.lv = lv; r.la = la; r.ld = ld; r.dn = dn;
        r.ir = ir; r.ia = ia; r.er = er; r.ea = ea;
        r.ew = ew; r.wa = wa; r.wd = wd;
        r.exp_ready = rdy; r.exp_ifu = ei; r.exp_exec = ee; r.exp_cnt = ec;
        return r;
    endfunction

    initial begin
        vec_t vecs[$];
        string tag;

        // rst lv la ld dn | ir ia er ea ew wa wd | ready ifu exec count
        vecs.push_back(v(0, 0, 0,       0,        0, 0, 0,       0, 0,       0, 0,       0,        0, 0,        0,        0));
        vecs.push_back(v(1, 1, 12'o200, 12'o1177, 0, 1, 12'o200, 1, 12'o200, 0, 0,       0,        0, 0,        0,        1));
        vecs.push_back(v(1, 1, 12'o201, 12'o7001, 0, 0, 0,       0, 0,       0, 0,       0,        0, 0,        0,        2));
        vecs.push_back(v(1, 1, 12'o202, 12'o3210, 0, 0, 0,       0, 0,       0, 0,       0,        0, 0,        0,        3));
        vecs.push_back(v(1, 1, 12'o203, 12'o7402, 0, 0, 0,       0, 0,       1, 12'o200, 0,        0, 0,        0,        4));
        vecs.push_back(v(1, 0, 0,       0,        0, 1, 12'o201, 1, 12'o202, 0, 0,       0,        0, 0,        0,        4));
        vecs.push_back(v(1, 0, 0,       0,        1, 1, 12'o200, 1, 12'o201, 0, 0,       0,        0, 0,        0,        4));
        vecs.push_back(v(1, 0, 0,       0,        0, 0, 0,       0, 0,       0, 0,       0,        1, 0,        0,        4));
        vecs.push_back(v(1, 0, 0,       0,        0, 1, 12'o200, 0, 0,       0, 0,       0,        1, 12'o1177, 0,        4));
        vecs.push_back(v(1, 0, 0,       0,        0, 1, 12'o201, 0, 0,       0, 0,       0,        1, 12'o7001, 0,        4));
        vecs.push_back(v(1, 0, 0,       0,        0, 1, 12'o202, 0, 0,       0, 0,       0,        1, 12'o3210, 0,        4));
        vecs.push_back(v(1, 0, 0,       0,        0, 1, 12'o203, 0, 0,       0, 0,       0,        1, 12'o7402, 0,        4));
        vecs.push_back(v(1, 0, 0,       0,        0, 1, 12'o300, 1, 12'o300, 1, 12'o300, 12'o4321, 1, 12'o4321, 12'o4321, 4));
        vecs.push_back(v(1, 0, 0,       0,        0, 1, 12'o201, 0, 0,       0, 0,       0,        1, 12'o7001, 12'o4321, 4));
        vecs.push_back(v(1, 0, 0,       0,        0, 0, 0,       0, 0,       1, 12'o201, 0,        1, 12'o7001, 12'o4321, 4));
        for (int k = 0; k < 4; k++)
            vecs.push_back(v(1, 0, 0,   0,        0, 0, 0,       0, 0,       0, 0,       0,        1, 12'o7001, 12'o4321, 4));
        vecs.push_back(v(1, 0, 0,       0,        0, 1, 12'o201, 0, 0,       0, 0,       0,        1, 12'o0000, 12'o4321, 4));
        vecs.push_back(v(1, 1, 12'o200, 12'o7777, 0, 0, 0,       1, 12'o200, 0, 0,       0,        1, 12'o0000, 12'o1177, 4));
        vecs.push_back(v(0, 0, 0,       0,        0, 1, 12'o202, 1, 12'o203, 0, 0,       0,        0, 0,        0,        0));
        vecs.push_back(v(1, 0, 0,       0,        1, 0, 0,       0, 0,       0, 0,       0,        0, 0,        0,        0));
        vecs.push_back(v(1, 0, 0,       0,        0, 0, 0,       0, 0,       0, 0,       0,        1, 0,        0,        0));
        vecs.push_back(v(1, 0, 0,       0,        0, 1, 12'o203, 1, 12'o200, 0, 0,       0,        1, 12'o7402, 12'o1177, 0));

        reset_n = 1'b0;
        idle_inputs();

        for (int i = 0; i < vecs.size(); i++) begin
            reset_n      = vecs[i].rst_n;
            load_valid   = vecs[i].lv;
            load_addr    = vecs[i].la;
            load_data    = vecs[i].ld;
            load_done    = vecs[i].dn;
            ifu_rd_req   = vecs[i].ir;
            ifu_rd_addr  = vecs[i].ia;
            exec_rd_req  = vecs[i].er;
            exec_rd_addr = vecs[i].ea;
            exec_wr_req  = vecs[i].ew;
            exec_wr_addr = vecs[i].wa;
            exec_wr_data = vecs[i].wd;
            tick();
            tag = $sformatf("vec%0d", i);
            check({tag, " ready"}, {12'd0, mem_ready}, {12'd0, vecs[i].exp_ready});
            check({tag, " ifu"}, {1'b0, ifu_rd_data}, {1'b0, vecs[i].exp_ifu});
            check({tag, " exec"}, {1'b0, exec_rd_data}, {1'b0, vecs[i].exp_exec});
            check({tag, " count"}, load_count, vecs[i].exp_cnt);
        end

        // Seed the top 16 words (including 7777) through the operand write port.
        idle_inputs();
        for (int k = 0; k < 16; k++) begin
            exec_wr_req  = 1'b1;
            exec_wr_addr = 12'o7760 + AW'(k);
            exec_wr_data = DW'($urandom);
            tick();
        end

        // Random mixed traffic in a 16-word window so collisions are frequent.
        for (int n = 0; n < 400; n++) begin
            ifu_rd_req   = 1'($urandom_range(0, 1));
            ifu_rd_addr  = 12'o7760 + AW'($urandom_range(0, 15));
            exec_rd_req  = 1'($urandom_range(0, 1));
            exec_rd_addr = 12'o7760 + AW'($urandom_range(0, 15));
            exec_wr_req  = 1'($urandom_range(0, 1));
            exec_wr_addr = 12'o7760 + AW'($urandom_range(0, 15));
            exec_wr_data = DW'($urandom);
            load_valid   = ($urandom_range(0, 7) == 0);
            load_addr    = 12'o7760 + AW'($urandom_range(0, 15));
            load_data    = DW'($urandom);
            tick();
            check_model($sformatf("rand%0d", n));
        end

        // Loader counter saturation, final word written together with load_done.
        idle_inputs();
        reset_n = 1'b0;
        tick();
        check_model("sat reset");
        reset_n = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            load_valid = 1'b1;
            load_addr  = AW'(i);
            load_data  = DW'(i * 7 + 3);
            load_done  = (i == DEPTH);
            tick();
            if (i >= DEPTH - 1) begin
                check_model($sformatf("sat load%0d", i));
                check($sformatf("sat limit%0d", i), load_count, 13'd4096);
            end
        end
        idle_inputs();
        tick();
        check_model("sat ready");
        ifu_rd_req   = 1'b1;
        ifu_rd_addr  = 12'o7777;
        exec_rd_req  = 1'b1;
        exec_rd_addr = 12'o0000;
        tick();
        check_model("sat read");
        check("sat last word", {1'b0, exec_rd_data}, 13'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pdp8_mem_unit.md
# pdp8_mem_unit

Unified 4096-word x 12-bit main memory for the PDP-8 core. It serves two clients: the IFD instruction-fetch read port, and the execution unit's operand read and write ports. A loader port initialises memory after reset, and `mem_ready` gates the start of instruction fetch. Reads are registered, so fetched words are stable from the rising edge after the request until the next accepted read on that port.

## Interface
- `ADDR_WIDTH`, 12, word address width.
- `DATA_WIDTH`, 12, word width.
- `DEPTH`, 4096, number of words (2**ADDR_WIDTH).

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `load_valid`  in  1  loader write strobe.
- `load_addr`  in  ADDR_WIDTH  loader word address.
- `load_data`  in  DATA_WIDTH  loader word.
- `load_done`  in  1  loader finished; leave LOAD.
- `mem_ready`  out  1  high in RUN; IFD must not fetch while low.
- `ifu_rd_req`  in  1  instruction read request.
- `ifu_rd_addr`  in  ADDR_WIDTH  instruction address.
- `ifu_rd_data`  out  DATA_WIDTH  fetched instruction word.
- `exec_rd_req`  in  1  operand read request.
- `exec_rd_addr`  in  ADDR_WIDTH  operand address.
- `exec_rd_data`  out  DATA_WIDTH  operand word.
- `exec_wr_req`  in  1  operand write request.
- `exec_wr_addr`  in  ADDR_WIDTH  write address.
- `exec_wr_data`  in  DATA_WIDTH  write data.
- `load_count`  out  ADDR_WIDTH+1  words written by loader since reset (saturating).

## Operation
- FSM has two states, LOAD and RUN. Reset enters LOAD. LOAD goes to RUN on the edge where `load_done`=1. RUN is left only by reset.
- LOAD:
  - `load_valid`=1 writes `load_data` to `mem[load_addr]` and increments `load_count`. The counter saturates at DEPTH.
  - If `load_valid` and `load_done` are both high, the word is written, then the FSM enters RUN.
  - ifu and exec requests are ignored; read data outputs hold 0.
- RUN:
  - `load_valid` is ignored and `load_count` is frozen.
  - `exec_wr_req`=1 writes `mem[exec_wr_addr]`.
  - `ifu_rd_req`=1 registers `mem[ifu_rd_addr]` into `ifu_rd_data`.
  - `exec_rd_req`=1 registers `mem[exec_rd_addr]` into `exec_rd_data`.
  - All three ports may be active in the same cycle; there is no arbitration and no back-pressure.
- Write-first collision: a read and an exec write to the same address in the same cycle returns the new write data. This applies to either read port.
- Read data outputs hold their last value while their request is low.
- The memory array is not cleared by reset. Contents survive reset, and reset mid-LOAD keeps already-loaded words.
- Addresses use the full ADDR_WIDTH and wrap naturally. Address 7777 is valid; there are no out-of-range accesses.

## Timing
- Reset values: `mem_ready`=0, `ifu_rd_data`=0, `exec_rd_data`=0, `load_count`=0, FSM in LOAD.
- `mem_ready` rises on the first edge after the edge that sampled `load_done`=1.
- Read latency is 1 cycle. For a request sampled at edge N, data is valid from just after edge N until the next accepted read on that port. It can therefore be sampled at the following falling edge.
- Write latency is 1 cycle: a write at edge N is visible to any read sampled at edge N (write-first) or later.
- A request sampled in the same edge as the LOAD-to-RUN transition is ignored. The first serviceable request is sampled at the first edge where `mem_ready`=1.
- Reset asserted during RUN: `mem_ready` drops on that edge, and any in-flight read result is replaced by 0.

## Test plan
- Reset release: load 4 words (addr 0200..0203 = 1177, 7001, 3210, 7402) -> `load_count`=4, `mem_ready` low. Pulse `load_done` -> `mem_ready`=1 one edge later.
- Fetch sequence: `ifu_rd_req` at 0200..0203 on consecutive cycles -> `ifu_rd_data` = 1177, 7001, 3210, 7402, each valid one edge after its request.
- Write-first collision: in one cycle, `exec_wr_req` to 0300 with 4321, `exec_rd_req` 0300 and `ifu_rd_req` 0300 -> both read outputs = 4321 next edge.
- Hold behaviour: read 0201, then drop `ifu_rd_req` for 5 cycles while exec writes 0201=0000 -> `ifu_rd_data` stays 7001 until re-requested, then reads 0000.
- Requests during LOAD and `load_valid` during RUN: both ignored. Outputs stay 0 during LOAD; a RUN `load_valid` to 0200 leaves 1177 intact and `load_count` unchanged.
- Reset mid-RUN, then `load_done` with no loads -> `mem_ready` 0 then 1, `load_count`=0, earlier contents (0200=1177) still readable.
